// File: rtl/uart_tx_parity_if.sv
// ---------------------------------------------------------------------------
// uart_tx_parity_if
// Host-side byte interface of the UART transmitter, bundled with the serial
// line and status outputs.
//   tx_start : host request to send data_in (honoured only while idle)
//   data_in  : byte to transmit, captured on the accepting edge
//   tx       : serial line, idle high
//   tx_busy  : high from the accepting edge until the frame ends
//   tx_done  : one-cycle pulse after the stop bit completes
// master = host side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_parity_if;
    logic       tx_start;
    logic [7:0] data_in;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output data_in,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  data_in,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_parity.sv
// ---------------------------------------------------------------------------
// uart_tx_parity
// UART transmitter: start bit, 8 data bits LSB-first, optional even-parity
// bit (XOR of the data byte), stop bit. Each bit lasts CLK_DIV clocks.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of uart_tx_parity_if (tx_start, data_in in;
//           tx, tx_busy, tx_done out). All outputs are registered.
// Parameters:
//   CLK_DIV   : clocks per bit period, 2..65535
//   PARITY_EN : 1 = 11-bit frame with parity, 0 = 10-bit frame
// ---------------------------------------------------------------------------
module uart_tx_parity #(
    parameter int unsigned CLK_DIV   = 868,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_parity_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 32'd1);

    // Parity bit sent on the line: XOR of all data bits.
    function automatic logic parity_f(input logic [7:0] data);
        return ^data;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] baud_q,  baud_d;
    logic [2:0]  bit_q,   bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q,   par_d;
    logic        tx_q,    tx_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic        baud_end_s;
    logic        accept_s;

    assign baud_end_s = (baud_q == BAUD_LAST);
    // tx_busy is low exactly in IDLE, so only IDLE can accept a request.
    assign accept_s   = (state_q == ST_IDLE) && bus.tx_start;

    // State and datapath registers, async reset to the idle line state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: every non-idle state advances at the end of its bit period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s && (bit_q == 3'd7)) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath logic: tx for the next bit is loaded on the edge
    // that ends the current one, so the line is always a flop output.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                if (accept_s) begin
                    shift_d = bus.data_in;
                    par_d   = parity_f(bus.data_in);
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    bit_d  = 3'd0;
                    tx_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        tx_d = PARITY_EN ? par_q : 1'b1;
                    end else begin
                        // Next data bit is the one above the current LSB.
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    tx_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_parity
// Bench for uart_tx_parity. Two instances share clk/rst_n: one with parity
// (11-bit frame), one without (10-bit frame), both at 4 clocks per bit.
// Expected line levels come from a frame model indexed by cycle offset from
// the accepting edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_parity;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;

    uart_tx_parity_if bus_p ();
    uart_tx_parity_if bus_n ();

    uart_tx_parity #(.CLK_DIV(DIV), .PARITY_EN(1'b1)) dut_p (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p)
    );

    uart_tx_parity #(.CLK_DIV(DIV), .PARITY_EN(1'b0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic cap_tx   [0:127];
    logic cap_busy [0:127];
    logic cap_done [0:127];

    // ---------------- reference model ----------------
    function automatic logic odd_ones(input logic [7:0] d);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n = n + int'(d[i]);
        return (n % 2) == 1;
    endfunction

    // Line level k cycles after the accepting edge.
    function automatic logic exp_line(input logic [7:0] d, input bit pen, input int k);
        int p;
        if (k < 0) return 1'b1;
        p = k / DIV;
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
        if (pen && p == 9) return odd_ones(d);
        return 1'b1;
    endfunction

    // ---------------- access helpers ----------------
    task automatic drive(input bit sel, input logic st, input logic [7:0] d);
        if (sel) begin
            bus_n.tx_start = st;
            bus_n.data_in  = d;
        end else begin
            bus_p.tx_start = st;
            bus_p.data_in  = d;
        end
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? bus_n.tx : bus_p.tx;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? bus_n.tx_busy : bus_p.tx_busy;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? bus_n.tx_done : bus_p.tx_done;
    endfunction

    // Start a frame and record outputs at each falling edge after the
    // accepting edge (index 0 = first cycle after acceptance). Optionally
    // pulse tx_start at index inj_k, or re-request as soon as tx_done is seen.
    task automatic capture(input bit sel, input logic [7:0] d, input int len,
                           input int inj_k, input logic [7:0] inj_d,
                           input bit b2b, input logic [7:0] b2b_d);
        bit b2b_pending;
        int clr_at;
        b2b_pending = b2b;
        clr_at = 0;
        @(negedge clk);
        drive(sel, 1'b1, d);
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == clr_at) drive(sel, 1'b0, 8'h00);
            cap_tx[k]   = get_tx(sel);
            cap_busy[k] = get_busy(sel);
            cap_done[k] = get_done(sel);
            if (k == inj_k) begin
                drive(sel, 1'b1, inj_d);
                clr_at = k + 1;
            end else if (b2b_pending && cap_done[k] === 1'b1) begin
                drive(sel, 1'b1, b2b_d);
                b2b_pending = 1'b0;
                clr_at = k + 1;
            end
        end
        drive(sel, 1'b0, 8'h00);
    endtask

    function automatic int first_done(input int len);
        for (int k = 0; k < len; k++) if (cap_done[k] === 1'b1) return k;
        return -1;
    endfunction
    function automatic int count_done(input int len);
        int n;
        n = 0;
        for (int k = 0; k < len; k++) if (cap_done[k] === 1'b1) n++;
        return n;
    endfunction
    function automatic int count_busy(input int len);
        int n;
        n = 0;
        for (int k = 0; k < len; k++) if (cap_busy[k] === 1'b1) n++;
        return n;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus_p.tx, bus_p.tx_busy, bus_p.tx_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hold got %b%b%b exp 100", bus_p.tx, bus_p.tx_busy, bus_p.tx_done);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus_p.tx, bus_p.tx_busy, bus_p.tx_done, bus_n.tx, bus_n.tx_busy, bus_n.tx_done} !== 6'b100100) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d got p=%b%b%b n=%b%b%b exp 100", k,
                         bus_p.tx, bus_p.tx_busy, bus_p.tx_done, bus_n.tx, bus_n.tx_busy, bus_n.tx_done);
            end
        end
    endtask

    task automatic test_single_parity();
        logic exp_seq [0:10];
        int   v;
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        capture(1'b0, 8'hA5, 60, -1, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 60; k++) begin
            n_tests++;
            if (cap_tx[k] !== exp_line(8'hA5, 1'b1, k)) begin
                n_fail++;
                $display("FAIL a5_line k=%0d got %b exp %b", k, cap_tx[k], exp_line(8'hA5, 1'b1, k));
            end
        end
        for (int i = 0; i < 11; i++) begin
            n_tests++;
            if (cap_tx[i*DIV+2] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL a5_bit%0d got %b exp %b", i, cap_tx[i*DIV+2], exp_seq[i]);
            end
        end
        v = first_done(60);
        n_tests++;
        if (v != 44) begin
            n_fail++;
            $display("FAIL a5_done_at got %0d exp 44", v);
        end
        v = count_done(60);
        n_tests++;
        if (v != 1) begin
            n_fail++;
            $display("FAIL a5_done_count got %0d exp 1", v);
        end
        v = count_busy(60);
        n_tests++;
        if (v != 44 || cap_busy[43] !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_busy_cycles got %0d exp 44", v);
        end
    endtask

    task automatic test_parity_polarity();
        logic [7:0] bytes [0:1];
        logic       exp_par [0:1];
        logic [7:0] rx_d;
        logic       rx_par, err, err_inv;
        bytes   = '{8'h07, 8'h00};
        exp_par = '{1'b1, 1'b0};
        for (int f = 0; f < 2; f++) begin
            capture(1'b0, bytes[f], 50, -1, 8'h00, 1'b0, 8'h00);
            // Receive path: sample mid-bit, then check parity.
            for (int i = 0; i < 8; i++) rx_d[i] = cap_tx[(i+1)*DIV+2];
            rx_par  = cap_tx[9*DIV+2];
            err     = (rx_par !== odd_ones(rx_d));
            err_inv = (~rx_par !== odd_ones(rx_d));
            n_tests++;
            if (rx_par !== exp_par[f]) begin
                n_fail++;
                $display("FAIL par_bit byte=%h got %b exp %b", bytes[f], rx_par, exp_par[f]);
            end
            n_tests++;
            if (rx_d !== bytes[f]) begin
                n_fail++;
                $display("FAIL par_rxdata got %h exp %h", rx_d, bytes[f]);
            end
            n_tests++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL par_err byte=%h got %b exp 0", bytes[f], err);
            end
            n_tests++;
            if (err_inv !== 1'b1) begin
                n_fail++;
                $display("FAIL par_err_inv byte=%h got %b exp 1", bytes[f], err_inv);
            end
        end
    endtask

    task automatic test_back_to_back();
        int v;
        capture(1'b1, 8'h3C, 90, -1, 8'h00, 1'b1, 8'hC3);
        v = first_done(90);
        n_tests++;
        if (v != 40) begin
            n_fail++;
            $display("FAIL b2b_first_done got %0d exp 40", v);
        end
        for (int k = 0; k < 90; k++) begin
            logic e;
            e = (k <= 40) ? exp_line(8'h3C, 1'b0, k) : exp_line(8'hC3, 1'b0, k - 41);
            n_tests++;
            if (cap_tx[k] !== e) begin
                n_fail++;
                $display("FAIL b2b_line k=%0d got %b exp %b", k, cap_tx[k], e);
            end
        end
        n_tests++;
        if (cap_busy[40] !== 1'b0 || cap_busy[41] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_edge got %b%b exp 01", cap_busy[40], cap_busy[41]);
        end
        n_tests++;
        if (cap_done[81] !== 1'b1 || count_done(90) != 2) begin
            n_fail++;
            $display("FAIL b2b_second_done got %b count %0d exp 1 count 2", cap_done[81], count_done(90));
        end
    endtask

    task automatic test_busy_reject();
        int v;
        capture(1'b0, 8'h55, 80, 4*DIV+1, 8'hFF, 1'b0, 8'h00);
        for (int k = 0; k < 80; k++) begin
            n_tests++;
            if (cap_tx[k] !== exp_line(8'h55, 1'b1, k)) begin
                n_fail++;
                $display("FAIL rej_line k=%0d got %b exp %b", k, cap_tx[k], exp_line(8'h55, 1'b1, k));
            end
        end
        v = count_done(80);
        n_tests++;
        if (v != 1 || first_done(80) != 44) begin
            n_fail++;
            $display("FAIL rej_done got count %0d at %0d exp 1 at 44", v, first_done(80));
        end
        v = count_busy(80);
        n_tests++;
        if (v != 44) begin
            n_fail++;
            $display("FAIL rej_busy got %0d exp 44", v);
        end
    endtask

    task automatic test_reset_mid();
        // Stop recording in the first cycle of data bit 5.
        capture(1'b0, 8'h5A, 6*DIV+1, -1, 8'h00, 1'b0, 8'h00);
        n_tests++;
        if (cap_busy[6*DIV] !== 1'b1 || cap_tx[6*DIV] !== exp_line(8'h5A, 1'b1, 6*DIV)) begin
            n_fail++;
            $display("FAIL mid_prereset got busy %b tx %b exp 1 %b", cap_busy[6*DIV], cap_tx[6*DIV],
                     exp_line(8'h5A, 1'b1, 6*DIV));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus_p.tx, bus_p.tx_busy, bus_p.tx_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_async got %b%b%b exp 100", bus_p.tx, bus_p.tx_busy, bus_p.tx_done);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_tests++;
            if ({bus_p.tx, bus_p.tx_busy, bus_p.tx_done} !== 3'b100) begin
                n_fail++;
                $display("FAIL mid_idle k=%0d got %b%b%b exp 100", k, bus_p.tx, bus_p.tx_busy, bus_p.tx_done);
            end
        end
        capture(1'b0, 8'h81, 50, -1, 8'h00, 1'b0, 8'h00);
        n_tests++;
        if (first_done(50) != 44 || cap_tx[DIV+1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_restart got done %0d bit0 %b exp 44 1", first_done(50), cap_tx[DIV+1]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            bit         sel, pen;
            logic [7:0] d, junk;
            int         nb, len, inj, v;
            sel  = 1'($urandom_range(0, 1));
            pen  = ~sel;
            d    = 8'($urandom_range(0, 255));
            junk = 8'($urandom_range(0, 255));
            nb   = pen ? 11 : 10;
            len  = nb*DIV + 6;
            inj  = (it % 2 == 0) ? int'($urandom_range(1, nb*DIV - 3)) : -1;
            capture(sel, d, len, inj, junk, 1'b0, 8'h00);
            for (int k = 0; k < len; k++) begin
                n_tests++;
                if (cap_tx[k] !== exp_line(d, pen, k)) begin
                    n_fail++;
                    $display("FAIL rand_line it=%0d byte=%h pen=%0d k=%0d got %b exp %b",
                             it, d, pen, k, cap_tx[k], exp_line(d, pen, k));
                end
            end
            v = first_done(len);
            n_tests++;
            if (v != nb*DIV || count_done(len) != 1) begin
                n_fail++;
                $display("FAIL rand_done it=%0d got %0d exp %0d", it, v, nb*DIV);
            end
            v = count_busy(len);
            n_tests++;
            if (v != nb*DIV) begin
                n_fail++;
                $display("FAIL rand_busy it=%0d got %0d exp %0d", it, v, nb*DIV);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_p.tx_start = 1'b0;
        bus_p.data_in  = 8'h00;
        bus_n.tx_start = 1'b0;
        bus_n.data_in  = 8'h00;
        test_reset();
        test_single_parity();
        test_parity_polarity();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
Serial UART transmitter that frames one byte at a time: start bit, 8 data bits LSB-first, optional even-parity bit, and stop bit. It is the transmit-side counterpart of the receive-path parity checker, which flags an error when the received parity bit differs from XOR of the data byte. This block therefore generates the parity bit as XOR of the data byte. It sits between the host-side byte interface and the tx pin, with its own baud-rate divider.

Parameters:
CLK_DIV, 868, clock cycles per bit period (100 MHz / 115200); legal range 2..65535
PARITY_EN, 1, 1 = send the parity bit (11-bit frame); 0 = omit it (10-bit frame)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
tx_start  input  1  request to send data_in; sampled only while tx_busy=0
data_in  input  8  byte to transmit; captured on the accepting edge
tx  output  1  serial line; idle high
tx_busy  output  1  high from the accepting edge until the frame ends
tx_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame: outputs return to their reset values immediately, without waiting for a clock edge.
  - tx goes high, which aborts the frame.
  - Nothing resumes after reset is released.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_start=1 at a rising edge, on that edge:
    - latch data_in into the shift register;
    - compute par = XOR of data_in and latch it;
    - set tx=0, tx_busy=1, baud counter=0;
    - go to START.
- Bit timing: each of START, DATA (per bit), PARITY and STOP holds tx for exactly CLK_DIV cycles.
  - The baud counter counts 0..CLK_DIV-1.
  - The transition happens on the edge where the counter equals CLK_DIV-1; the counter then returns to 0.
- START -> DATA:
  - tx = shift[0].
  - Bit counter = 0.
- DATA:
  - At the end of each bit period, shift right and increment the bit counter.
  - When 8 bits have been sent: if PARITY_EN=1, set tx=par and go to PARITY; otherwise set tx=1 and go to STOP.
- PARITY -> STOP: tx=1.
- STOP -> IDLE, on the same edge:
  - tx stays 1;
  - tx_busy=0;
  - tx_done=1.
- tx_done clears on the following edge.
- Frame length: from the accepting edge to the tx_done edge is (10 + PARITY_EN) x CLK_DIV cycles.
- Back-to-back frames: tx_start is honoured in the cycle where tx_done=1, because the block is in IDLE with tx_busy=0. The next start bit then follows the previous stop bit with no idle gap.
- tx_start while tx_busy=1 is ignored. It is not queued, and there is no error flag.
- data_in changes after acceptance do not affect the frame in flight.
- Parity convention: parity bit = XOR of the 8 data bits. The receive-side check passes exactly when the received parity bit equals this value.
  - 0x00 -> 0; 0x01 -> 1; 0xFF -> 0; 0xA5 -> 0; 0x07 -> 1.

Test Plan:
- Reset behaviour. Hold rst_n=0 for 5 cycles, then release with tx_start=0 -> tx=1, tx_busy=0, tx_done=0 steady for 100 cycles.
- Single frame with parity. CLK_DIV=4, PARITY_EN=1, data_in=0xA5, tx_start pulse.
  - tx sampled every 4 cycles = 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop).
  - tx_done pulses at cycle 44 after acceptance.
  - tx_busy is high for exactly 44 cycles.
- Parity polarity. Send 0x07 and 0x00 -> parity bits 1 and 0.
  - Loop tx into the receive path and feed its parity check -> parity_err=0 for both frames.
  - Invert the parity bit in the loop -> parity_err=1.
- No parity / back-to-back. PARITY_EN=0, CLK_DIV=4, send 0x3C, then assert tx_start=1 with data_in=0xC3 in the tx_done cycle.
  - First frame lasts 40 cycles; the second start bit begins immediately with no idle cycle.
  - Data bits are 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1.
- Busy rejection. During a 0x55 frame, pulse tx_start with data_in=0xFF at bit 3 -> waveform is still 0x55; exactly one tx_done; no second frame.
- Reset mid-frame. Assert rst_n=0 asynchronously (not at a clock edge) during data bit 5 -> tx=1 and tx_busy=0 within the same cycle; after release the line stays idle until a new tx_start.
